ps2_scan_receiver: RTL and testbench

Receives the serial PS/2 keyboard stream and delivers one 8-bit make code with a one-cycle `got_data` strobe per key press. It sits directly upstream of the key-driven ID/selection counters, which step on `scan_code` values such as 8'h7A and 8'h69 when `got_data` is high. The block synchronizes and deglitches the PS/2 lines, deserializes 11-bit frames, checks parity and stop bits, and swallows break sequences so that each key press produces exactly one strobe.

---
 rtl/ps2_scan_receiver.sv | 128 ++++++++++++
 tb/tb_ps2_scan_receiver.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_receiver.sv
// ps2_scan_receiver: PS/2 keyboard frame receiver delivering one make code strobe per key press
module ps2_scan_receiver #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 100000,
    parameter int CNT_W      = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_scan_code,
    output logic       o_got_data,
    output logic       o_extended,
    output logic       o_rx_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {S_IDLE, S_DATA, S_PARITY, S_STOP, S_DECODE} state_t;

    state_t           r_state, w_next;
    logic [1:0]       r_clk_s, r_dat_s;
    logic [FW-1:0]    r_fcnt;
    logic             r_fclk, r_fclk_d;
    logic [CNT_W-1:0] r_to_cnt;
    logic [7:0]       r_shreg, r_scan;
    logic [2:0]       r_bit_cnt;
    logic             r_par, r_ext, r_brk, r_extended, r_err;
    logic             w_fall, w_data, w_busy, w_timeout, w_good, w_got;

    assign w_fall    = r_fclk_d & ~r_fclk;
    assign w_data    = r_dat_s[1];
    assign w_busy    = (r_state == S_DATA) || (r_state == S_PARITY) || (r_state == S_STOP);
    assign w_timeout = w_busy && (r_to_cnt == CNT_W'(TIMEOUT));
    assign w_good    = w_data && (^{r_shreg, r_par});
    assign w_got     = (r_state == S_DECODE) && (r_shreg != 8'hE0) && (r_shreg != 8'hF0) && !r_brk;

    // Decode-cycle outputs bypass the holding registers so code and strobe coincide
    assign o_got_data  = w_got;
    assign o_scan_code = w_got ? r_shreg : r_scan;
    assign o_extended  = w_got ? r_ext : r_extended;
    assign o_rx_err    = r_err | w_timeout;

    // Synchronize both lines and debounce the clock; idle bus level is high
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_s  <= 2'b11;
            r_dat_s  <= 2'b11;
            r_fcnt   <= '0;
            r_fclk   <= 1'b1;
            r_fclk_d <= 1'b1;
        end else begin
            r_clk_s  <= {r_clk_s[0], i_ps2_clk};
            r_dat_s  <= {r_dat_s[0], i_ps2_data};
            r_fclk_d <= r_fclk;
            if (r_clk_s[1] == r_fclk) begin
                r_fcnt <= '0;
            end else if (r_fcnt == FW'(FILTER_LEN - 1)) begin
                r_fcnt <= '0;
                r_fclk <= r_clk_s[1];
            end else begin
                r_fcnt <= r_fcnt + FW'(1);
            end
        end
    end

    // Frame state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic; a timeout aborts any partially received frame
    always_comb begin
        w_next = r_state;
        if (w_timeout) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   w_next = (w_fall && !w_data) ? S_DATA : S_IDLE;
                S_DATA:   w_next = (w_fall && r_bit_cnt == 3'd7) ? S_PARITY : S_DATA;
                S_PARITY: w_next = w_fall ? S_STOP : S_PARITY;
                S_STOP:   w_next = w_fall ? (w_good ? S_DECODE : S_IDLE) : S_STOP;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    // Deserializer, timeout counter, error strobe and make/break/extended bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt   <= '0;
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
            r_par      <= 1'b0;
            r_ext      <= 1'b0;
            r_brk      <= 1'b0;
            r_scan     <= '0;
            r_extended <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err    <= (r_state == S_STOP) && w_fall && !w_good && !w_timeout;
            r_to_cnt <= (!w_busy || w_fall || w_timeout) ? '0 : r_to_cnt + CNT_W'(1);
            if (r_state == S_IDLE && w_fall) r_bit_cnt <= '0;
            if (r_state == S_DATA && w_fall && !w_timeout) begin
                r_shreg[r_bit_cnt] <= w_data;
                r_bit_cnt          <= r_bit_cnt + 3'd1;
            end
            if (r_state == S_PARITY && w_fall) r_par <= w_data;
            if (w_timeout) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else if (r_state == S_DECODE) begin
                if (r_shreg == 8'hE0) begin
                    r_ext <= 1'b1;
                end else if (r_shreg == 8'hF0) begin
                    r_brk <= 1'b1;
                end else if (r_brk) begin
                    r_brk <= 1'b0;
                    r_ext <= 1'b0;
                end else begin
                    r_scan     <= r_shreg;
                    r_extended <= r_ext;
                    r_ext      <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_scan_receiver.sv
// tb_ps2_scan_receiver: directed frame scenarios for the PS/2 scan receiver
module tb_ps2_scan_receiver;
    logic       clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [7:0] scan_code;
    logic       got_data, extended, rx_err;
    int         checks = 0, failures = 0;
    int         got_total = 0, err_total = 0, overlap = 0, wide = 0;
    int         g0 = 0, e0 = 0;
    logic [7:0] last_code = 8'h00;
    logic       last_ext = 1'b0, prev_got = 1'b0, prev_err = 1'b0;

    ps2_scan_receiver #(.FILTER_LEN(4), .TIMEOUT(1000), .CNT_W(10)) dut (
        .clk(clk), .rst(rst), .i_ps2_clk(ps2_clk), .i_ps2_data(ps2_data),
        .o_scan_code(scan_code), .o_got_data(got_data), .o_extended(extended), .o_rx_err(rx_err)
    );

    always #5 clk = ~clk;

    // Strobe monitor: counts pulses, captures strobed code, flags overlap and long pulses
    always @(negedge clk) begin
        if (got_data === 1'b1) begin
            got_total++;
            last_code = scan_code;
            last_ext  = extended;
        end
        if (rx_err === 1'b1) err_total++;
        if (got_data === 1'b1 && rx_err === 1'b1) overlap++;
        if ((got_data === 1'b1 && prev_got) || (rx_err === 1'b1 && prev_err)) wide++;
        prev_got = (got_data === 1'b1);
        prev_err = (rx_err === 1'b1);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        cyc(20);
        ps2_clk = 1'b0;
        cyc(40);
        ps2_clk = 1'b1;
        cyc(20);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~^b ^ bad_par);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        cyc(20);
    endtask

    task automatic mark();
        g0 = got_total;
        e0 = err_total;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(5);
        rst = 1'b0;
        checks++; if (scan_code !== 8'h00) begin failures++; $display("FAIL reset_scan: got %h expected 00", scan_code); end
        checks++; if (got_data !== 1'b0) begin failures++; $display("FAIL reset_got: got %b expected 0", got_data); end
        checks++; if (extended !== 1'b0) begin failures++; $display("FAIL reset_ext: got %b expected 0", extended); end
        checks++; if (rx_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", rx_err); end
        cyc(20);
    endtask

    task automatic test_single();
        mark();
        send_frame(8'h7A, 1'b0);
        checks++; if (got_total - g0 !== 1) begin failures++; $display("FAIL single_got: got %0d expected 1", got_total - g0); end
        checks++; if (last_code !== 8'h7A) begin failures++; $display("FAIL single_code: got %h expected 7a", last_code); end
        checks++; if (last_ext !== 1'b0) begin failures++; $display("FAIL single_ext: got %b expected 0", last_ext); end
        checks++; if (err_total - e0 !== 0) begin failures++; $display("FAIL single_err: got %0d expected 0", err_total - e0); end
        checks++; if (scan_code !== 8'h7A) begin failures++; $display("FAIL single_hold: got %h expected 7a", scan_code); end
    endtask

    task automatic test_typematic();
        mark();
        send_frame(8'h69, 1'b0);
        send_frame(8'h69, 1'b0);
        checks++; if (got_total - g0 !== 2) begin failures++; $display("FAIL typematic_got: got %0d expected 2", got_total - g0); end
        checks++; if (last_code !== 8'h69) begin failures++; $display("FAIL typematic_code: got %h expected 69", last_code); end
    endtask

    task automatic test_break();
        mark();
        send_frame(8'h69, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h69, 1'b0);
        checks++; if (got_total - g0 !== 1) begin failures++; $display("FAIL break_got: got %0d expected 1", got_total - g0); end
        checks++; if (last_code !== 8'h69) begin failures++; $display("FAIL break_code: got %h expected 69", last_code); end
        checks++; if (err_total - e0 !== 0) begin failures++; $display("FAIL break_err: got %0d expected 0", err_total - e0); end
    endtask

    task automatic test_extended();
        mark();
        send_frame(8'hE0, 1'b0);
        send_frame(8'h7A, 1'b0);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h7A, 1'b0);
        checks++; if (got_total - g0 !== 1) begin failures++; $display("FAIL ext_got: got %0d expected 1", got_total - g0); end
        checks++; if (last_code !== 8'h7A) begin failures++; $display("FAIL ext_code: got %h expected 7a", last_code); end
        checks++; if (last_ext !== 1'b1) begin failures++; $display("FAIL ext_flag: got %b expected 1", last_ext); end
        send_frame(8'h69, 1'b0);
        checks++; if (got_total - g0 !== 2) begin failures++; $display("FAIL ext_after_got: got %0d expected 2", got_total - g0); end
        checks++; if (last_ext !== 1'b0) begin failures++; $display("FAIL ext_after_flag: got %b expected 0", last_ext); end
    endtask

    task automatic test_parity_err();
        mark();
        send_frame(8'h7A, 1'b1);
        checks++; if (err_total - e0 !== 1) begin failures++; $display("FAIL parity_err: got %0d expected 1", err_total - e0); end
        checks++; if (got_total - g0 !== 0) begin failures++; $display("FAIL parity_got: got %0d expected 0", got_total - g0); end
        send_frame(8'h69, 1'b0);
        checks++; if (got_total - g0 !== 1) begin failures++; $display("FAIL parity_next_got: got %0d expected 1", got_total - g0); end
        checks++; if (last_code !== 8'h69) begin failures++; $display("FAIL parity_next_code: got %h expected 69", last_code); end
    endtask

    task automatic test_timeout();
        mark();
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        cyc(890);
        checks++; if (err_total - e0 !== 0) begin failures++; $display("FAIL timeout_early: got %0d expected 0", err_total - e0); end
        cyc(150);
        checks++; if (err_total - e0 !== 1) begin failures++; $display("FAIL timeout_err: got %0d expected 1", err_total - e0); end
        cyc(100);
        send_frame(8'h7A, 1'b0);
        checks++; if (got_total - g0 !== 1) begin failures++; $display("FAIL timeout_next_got: got %0d expected 1", got_total - g0); end
        checks++; if (last_code !== 8'h7A) begin failures++; $display("FAIL timeout_next_code: got %h expected 7a", last_code); end
        checks++; if (err_total - e0 !== 1) begin failures++; $display("FAIL timeout_next_err: got %0d expected 1", err_total - e0); end
    endtask

    task automatic test_reset_mid();
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        checks++; if (scan_code !== 8'h00) begin failures++; $display("FAIL rstmid_scan: got %h expected 00", scan_code); end
        checks++; if (got_data !== 1'b0) begin failures++; $display("FAIL rstmid_got: got %b expected 0", got_data); end
        checks++; if (extended !== 1'b0) begin failures++; $display("FAIL rstmid_ext: got %b expected 0", extended); end
        checks++; if (rx_err !== 1'b0) begin failures++; $display("FAIL rstmid_err: got %b expected 0", rx_err); end
        cyc(50);
        mark();
        send_frame(8'hE0, 1'b0);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(20);
        send_frame(8'h7A, 1'b0);
        checks++; if (got_total - g0 !== 1) begin failures++; $display("FAIL rstpend_got: got %0d expected 1", got_total - g0); end
        checks++; if (last_code !== 8'h7A) begin failures++; $display("FAIL rstpend_code: got %h expected 7a", last_code); end
        checks++; if (last_ext !== 1'b0) begin failures++; $display("FAIL rstpend_ext: got %b expected 0", last_ext); end
    endtask

    task automatic test_glitch();
        mark();
        ps2_data = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ps2_clk = 1'b0;
            cyc(2);
            ps2_clk = 1'b1;
            cyc(30);
        end
        ps2_data = 1'b1;
        cyc(1200);
        checks++; if (err_total - e0 !== 0) begin failures++; $display("FAIL glitch_err: got %0d expected 0", err_total - e0); end
        checks++; if (got_total - g0 !== 0) begin failures++; $display("FAIL glitch_got: got %0d expected 0", got_total - g0); end
        send_frame(8'h69, 1'b0);
        checks++; if (last_code !== 8'h69) begin failures++; $display("FAIL glitch_next_code: got %h expected 69", last_code); end
    endtask

    task automatic test_strobes();
        checks++; if (overlap !== 0) begin failures++; $display("FAIL strobe_overlap: got %0d expected 0", overlap); end
        checks++; if (wide !== 0) begin failures++; $display("FAIL strobe_width: got %0d expected 0", wide); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_typematic();
        test_break();
        test_extended();
        test_parity_err();
        test_timeout();
        test_reset_mid();
        test_glitch();
        test_strobes();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
